// File: rtl/rd_buffer_mc.sv
// rtl/rd_buffer_mc.sv - multi-channel AXI read buffer with credit-gated bursts and width down-conversion
// Optional build macro RD_BUF_ERR_STICKY_EN makes both error outputs sticky until reset.
module rd_buffer_mc #(
  parameter int AXI_DATA_WIDTH  = 128,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int USER_DATA_WIDTH = 64,
  parameter int CH_NUM          = 2,
  parameter int CMD_DEPTH       = 16,
  parameter int DATA_DEPTH      = 64,
  localparam int CHW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CH_NUM-1:0]              rd_req_en,
  output logic [CH_NUM-1:0]              rd_cmd_ready,
  input  logic [CH_NUM*AXI_ADDR_WIDTH-1:0] rd_addr_in,
  input  logic [CH_NUM*8-1:0]            rd_burst_length,
  output logic [AXI_ADDR_WIDTH-1:0]      axi_ar_addr,
  output logic [7:0]                     axi_ar_burst_len,
  output logic                           axi_ar_req_en,
  input  logic                           axi_ar_ready,
  input  logic                           axi_r_valid,
  output logic                           axi_r_ready,
  input  logic [AXI_DATA_WIDTH-1:0]      axi_r_data,
  input  logic                           axi_r_last,
  output logic                           user_rd_valid,
  input  logic                           user_rd_ready,
  output logic [USER_DATA_WIDTH-1:0]     user_rd_data,
  output logic                           user_rd_last,
  output logic [CHW-1:0]                 user_rd_ch,
  output logic                           rd_cmd_fifo_err,
  output logic                           rd_data_fifo_err
);
  localparam int RATIO = AXI_DATA_WIDTH / USER_DATA_WIDTH;
  localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int CPW   = $clog2(CMD_DEPTH);
  localparam int DPW   = $clog2(DATA_DEPTH);
  localparam int UW    = DPW + 1;
  localparam int CMDW  = AXI_ADDR_WIDTH + 8;
  localparam int ENTW  = CHW + 1 + AXI_DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_DATA} state_t;

  state_t                    state_q;
  logic [CHW-1:0]            grant_ch_q, rr_ptr_q;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;
  logic [7:0]                len_q, beat_q;
  logic                      ar_valid_q, r_ready_q;

  logic [CMDW-1:0]  cmd_mem [CH_NUM][CMD_DEPTH];
  logic [CPW-1:0]   cmd_wp_q [CH_NUM];
  logic [CPW-1:0]   cmd_rp_q [CH_NUM];
  logic [CPW:0]     cmd_cnt_q [CH_NUM];
  logic [CH_NUM-1:0] cmd_full, cmd_nempty, cmd_push, cmd_pop;

  logic [ENTW-1:0]  dmem [DATA_DEPTH];
  logic [DPW-1:0]   d_wp_q, d_rp_q;
  logic [DPW:0]     d_cnt_q;
  logic [UW-1:0]    used_q, used_d;
  logic [ENTW-1:0]  d_head;

  logic                      out_valid_q, out_last_q;
  logic [CHW-1:0]            out_ch_q;
  logic [AXI_DATA_WIDTH-1:0] out_data_q;
  logic [SW-1:0]             slice_q;
  logic                      cmd_err_q, data_err_q;

  logic            ar_hs, r_hs, beat_end, d_pop, slice_end, take, grant;
  logic            cmd_err_ev, data_err_ev;
  logic [CHW-1:0]  cand;
  logic            cand_ok;
  logic [CMDW-1:0] cand_cmd;
  logic [7:0]      cand_len, rel;
  int              arb_idx;

  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      cmd_full[c]   = (cmd_cnt_q[c] == (CPW+1)'(CMD_DEPTH));
      cmd_nempty[c] = (cmd_cnt_q[c] != '0);
      cmd_push[c]   = rd_req_en[c] & ~cmd_full[c];
      cmd_pop[c]    = ar_hs && (grant_ch_q == CHW'(c));
    end
  end
  assign rd_cmd_ready = ~cmd_full;
  assign cmd_err_ev   = |(rd_req_en & cmd_full);

  // Round-robin: first non-empty channel at or after the pointer; no skipping on low credit.
  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    arb_idx = 0;
    for (int k = 0; k < CH_NUM; k++) begin
      arb_idx = (int'(rr_ptr_q) + k) % CH_NUM;
      if (!cand_ok && cmd_nempty[arb_idx]) begin
        cand_ok = 1'b1;
        cand    = CHW'(arb_idx);
      end
    end
  end
  assign cand_cmd = cmd_mem[cand][cmd_rp_q[cand]];
  assign cand_len = cand_cmd[CMDW-1 -: 8];
  assign grant    = (state_q == S_IDLE) && cand_ok &&
                    ((32'(DATA_DEPTH) - 32'(used_q)) >= (32'(cand_len) + 32'd1));

  assign ar_hs    = (state_q == S_AR) && axi_ar_ready;
  assign r_hs     = (state_q == S_DATA) && axi_r_valid;
  assign beat_end = r_hs && (axi_r_last || (beat_q == len_q));
  assign rel      = beat_end ? (len_q - beat_q) : 8'd0;
  assign data_err_ev = (r_hs && axi_r_last && (beat_q != len_q)) ||
                       (r_hs && (beat_q == len_q) && !axi_r_last) ||
                       (axi_r_valid && (state_q != S_DATA));

  assign d_head    = dmem[d_rp_q];
  assign slice_end = (slice_q == SW'(RATIO - 1));
  assign take      = out_valid_q && user_rd_ready;
  assign d_pop     = (d_cnt_q != '0) && (!out_valid_q || (take && slice_end));

  // Unpopped entries and reserved-but-unwritten beats both count against credit.
  assign used_d = UW'(32'(used_q) + (ar_hs ? 32'(len_q) + 32'd1 : 32'd0)
                      - (d_pop ? 32'd1 : 32'd0) - 32'(rel));

  always_ff @(posedge clk) begin
    for (int c = 0; c < CH_NUM; c++)
      if (cmd_push[c])
        cmd_mem[c][cmd_wp_q[c]] <= {rd_burst_length[c*8 +: 8],
                                    rd_addr_in[c*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]};
    if (r_hs) dmem[d_wp_q] <= {grant_ch_q, beat_end, axi_r_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_ch_q <= '0;
      rr_ptr_q   <= '0;
      ar_addr_q  <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (grant) begin
          state_q    <= S_AR;
          grant_ch_q <= cand;
          rr_ptr_q   <= (cand == CHW'(CH_NUM - 1)) ? '0 : cand + 1'b1;
          ar_addr_q  <= cand_cmd[AXI_ADDR_WIDTH-1:0];
          len_q      <= cand_len;
          ar_valid_q <= 1'b1;
        end
        S_AR: if (axi_ar_ready) begin
          state_q    <= S_DATA;
          ar_valid_q <= 1'b0;
          r_ready_q  <= 1'b1;
          beat_q     <= '0;
        end
        S_DATA: if (r_hs) begin
          beat_q <= beat_q + 8'd1;
          if (beat_end) begin
            state_q   <= S_IDLE;
            r_ready_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CH_NUM; c++) begin
        cmd_wp_q[c]  <= '0;
        cmd_rp_q[c]  <= '0;
        cmd_cnt_q[c] <= '0;
      end
      d_wp_q      <= '0;
      d_rp_q      <= '0;
      d_cnt_q     <= '0;
      used_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      slice_q     <= '0;
      cmd_err_q   <= 1'b0;
      data_err_q  <= 1'b0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (cmd_push[c]) cmd_wp_q[c] <= cmd_wp_q[c] + 1'b1;
        if (cmd_pop[c])  cmd_rp_q[c] <= cmd_rp_q[c] + 1'b1;
        if (cmd_push[c] && !cmd_pop[c])      cmd_cnt_q[c] <= cmd_cnt_q[c] + 1'b1;
        else if (!cmd_push[c] && cmd_pop[c]) cmd_cnt_q[c] <= cmd_cnt_q[c] - 1'b1;
      end
      if (r_hs)  d_wp_q <= d_wp_q + 1'b1;
      if (d_pop) d_rp_q <= d_rp_q + 1'b1;
      if (r_hs && !d_pop)      d_cnt_q <= d_cnt_q + 1'b1;
      else if (!r_hs && d_pop) d_cnt_q <= d_cnt_q - 1'b1;
      used_q <= used_d;
      if (d_pop) begin
        out_valid_q <= 1'b1;
        out_ch_q    <= d_head[ENTW-1 -: CHW];
        out_last_q  <= d_head[AXI_DATA_WIDTH];
        out_data_q  <= d_head[AXI_DATA_WIDTH-1:0];
        slice_q     <= '0;
      end else if (take) begin
        if (slice_end) out_valid_q <= 1'b0;
        else           slice_q     <= slice_q + 1'b1;
      end
`ifdef RD_BUF_ERR_STICKY_EN
      cmd_err_q  <= cmd_err_q | cmd_err_ev;
      data_err_q <= data_err_q | data_err_ev;
`else
      cmd_err_q  <= cmd_err_ev;
      data_err_q <= data_err_ev;
`endif
    end
  end

  assign axi_ar_addr      = ar_addr_q;
  assign axi_ar_burst_len = len_q;
  assign axi_ar_req_en    = ar_valid_q;
  assign axi_r_ready      = r_ready_q;
  assign user_rd_valid    = out_valid_q;
  assign user_rd_data     = out_data_q[int'(slice_q)*USER_DATA_WIDTH +: USER_DATA_WIDTH];
  assign user_rd_last     = out_valid_q && out_last_q && slice_end;
  assign user_rd_ch       = out_ch_q;
  assign rd_cmd_fifo_err  = cmd_err_q;
  assign rd_data_fifo_err = data_err_q;
endmodule
